// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: read-side packetizer for one channel FIFO.
// Requests the formatter once a full packet is buffered, then drains
// it as a framed burst.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   en               allow new requests (in-flight packet always completes)
//   pkt_len          length code: 0/1/2/3 -> 4/8/16/32 words
//   fifo_margin      free slots in the FIFO (avail = 2^DEPTH - margin)
//   fifo_rd_empty    FIFO empty flag
//   fifo_rd_en       FIFO read enable (data valid one cycle later)
//   fifo_rd_data     registered FIFO read data
//   fmt_req          packet request to the formatter
//   fmt_grant        formatter grant, only honoured while requesting
//   fmt_valid/start/end  framing of the outgoing burst
//   fmt_data         packet word (pass-through of fifo_rd_data)
//   busy             high whenever not idle
module fifo_pkt_reader #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       pkt_len,
    input  logic [DEPTH:0]   fifo_margin,
    input  logic             fifo_rd_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fmt_req,
    input  logic             fmt_grant,
    output logic             fmt_valid,
    output logic             fmt_start,
    output logic             fmt_end,
    output logic [WIDTH-1:0] fmt_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        DRAIN
    } state_t;

    localparam int MAX_COUNT = 1 << DEPTH;
    localparam logic [DEPTH:0] MAX_W = MAX_COUNT[DEPTH:0];

    state_t       state;
    state_t       state_d;
    logic [5:0]   len_q;
    logic [5:0]   rd_cnt;
    logic [5:0]   len_d;
    logic [DEPTH:0] avail;
    logic         avail_ok;
    logic         load;
    logic         last_rd;

    // Full-scale (64 words) is representable at DEPTH+1 bits.
    assign avail    = MAX_W - fifo_margin;
    assign avail_ok = 32'(avail) >= 32'(len_d);
    assign last_rd  = (rd_cnt == len_q - 6'd1);
    assign fmt_data = fifo_rd_data;

    always_comb begin
        len_d = 6'd4;
        unique case (pkt_len)
            2'd0: len_d = 6'd4;
            2'd1: len_d = 6'd8;
            2'd2: len_d = 6'd16;
            2'd3: len_d = 6'd32;
            default: len_d = 6'd4;
        endcase
    end

    always_comb begin
        state_d    = state;
        fmt_req    = 1'b0;
        fifo_rd_en = 1'b0;
        busy       = 1'b1;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (en && avail_ok) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                fmt_req = 1'b1;
                if (fmt_grant) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                fifo_rd_en = 1'b1;
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            rd_cnt <= '0;
        end else if (load) begin
            len_q  <= len_d;
            rd_cnt <= '0;
        end else if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 6'd1;
        end
    end

    // Framing tracks the read issued in the previous cycle, lining up
    // with the FIFO's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_valid <= 1'b0;
            fmt_start <= 1'b0;
            fmt_end   <= 1'b0;
        end else begin
            fmt_valid <= fifo_rd_en;
            fmt_start <= fifo_rd_en && (rd_cnt == 6'd0);
            fmt_end   <= fifo_rd_en && last_rd;
        end
    end

    // Sole reader: reads are only issued against words counted in avail.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_rd_empty));

endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side packetizer for one 64x32 channel FIFO. It watches the FIFO fill level and requests the downstream formatter/arbiter once a full packet of the configured length is buffered. On grant, it drains exactly that many words from the FIFO and emits them as a framed burst (start/end/valid). It sits between a channel FIFO's read port and the shared output formatter, and it is the only agent allowed to drive that FIFO's read enable.

## Interface

**Parameters**
- `DEPTH`, default 6: FIFO address width. Capacity is MAX_COUNT = 2^DEPTH = 64 words.
- `WIDTH`, default 32: data word width.

**Ports**
- `clk`, input, 1: system clock. Everything is on the rising edge.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `en`, input, 1: when low, no new request is issued. A packet already in flight still completes.
- `pkt_len`, input, 2: packet length code. 0 = 4 words, 1 = 8, 2 = 16, 3 = 32.
- `fifo_margin`, input, DEPTH+1: free slots reported by the FIFO. Available words = MAX_COUNT − fifo_margin.
- `fifo_rd_empty`, input, 1: FIFO empty flag.
- `fifo_rd_en`, output, 1: FIFO read enable. Read data is valid one cycle after this is asserted.
- `fifo_rd_data`, input, WIDTH: FIFO read data (registered inside the FIFO).
- `fmt_req`, output, 1: packet request to downstream.
- `fmt_grant`, input, 1: downstream grant. Sampled only in state REQ.
- `fmt_valid`, output, 1: `fmt_data` carries a packet word.
- `fmt_start`, output, 1: first word of the packet.
- `fmt_end`, output, 1: last word of the packet.
- `fmt_data`, output, WIDTH: packet word, driven directly from `fifo_rd_data`.
- `busy`, output, 1: high in any state other than IDLE.

## Operation

**States:** IDLE, REQ, SEND, DRAIN.

- **IDLE**
  - `avail` = MAX_COUNT − `fifo_margin`, computed at DEPTH+1 bits (range 0..64).
  - If `en` is high and `avail` ≥ len(`pkt_len`): latch the length into `len_q` (6 bits), clear `rd_cnt`, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `fmt_req` = 1.
  - When `fmt_grant` is sampled high, go to SEND.
  - `en` falling while in REQ does not withdraw the request.
- **SEND**
  - `fifo_rd_en` = 1 every cycle; `rd_cnt` increments each cycle.
  - When `rd_cnt` = `len_q` − 1, go to DRAIN.
- **DRAIN**
  - `fifo_rd_en` = 0. The last word is presented.
  - Go to IDLE.

**Output rules**
- `fmt_req`, `fifo_rd_en` and `busy` are Moore outputs of the state.
- `fmt_valid` is `fifo_rd_en` delayed one cycle.
- `fmt_start` is registered: set when the read with `rd_cnt` = 0 is issued.
- `fmt_end` is registered: set when the read with `rd_cnt` = `len_q` − 1 is issued.
- `fmt_data` = `fifo_rd_data` (combinational pass-through).
- Changes to `pkt_len` outside IDLE are ignored; `len_q` holds for the whole packet.
- `fmt_grant` outside REQ is ignored.

**Safety**
- The block never asserts `fifo_rd_en` while `fifo_rd_empty` = 1. This is guaranteed by the `avail` check, since this block is the sole reader of the FIFO.
- A 1-cycle protocol assertion flags any violation.

**Reset** (any time, including mid-SEND)
- State returns to IDLE; `len_q` and `rd_cnt` clear.
- All outputs go to 0. `fmt_data` follows the FIFO's reset data of 0.
- Any partial packet is discarded. No `fmt_end` is emitted after reset.

## Timing

- `avail` meets the threshold at cycle T (state IDLE) → `fmt_req` = 1 from T+1.
- A grant is accepted in the first REQ cycle at the earliest (T+1).
- Grant sampled at cycle G:
  - `fifo_rd_en` is high for cycles G+1 .. G+L.
  - `fmt_valid` is high for G+2 .. G+L+1.
  - `fmt_start` at G+2; `fmt_end` at G+L+1.
  - `busy` drops at G+L+2.
- Minimum request spacing: the next `fmt_req` rises no earlier than G+L+3, because IDLE lasts at least one cycle.
- Result: at least one idle cycle between the `fmt_end` of one packet and the `fmt_req` of the next.
- `fmt_req` falls at G+1.
- Wrap-around is handled entirely by the FIFO pointers. The reader only tracks `rd_cnt` within a packet.
- `avail` = 64 (FIFO full-scale) is legal and must not overflow.

## Test plan

- **Reset:** assert `rst_n` = 0 → all outputs 0 and `busy` = 0; release → no `fmt_req` while the FIFO is empty.
- **Threshold:** `pkt_len` = 0, write 0xA0..0xA2 → `fmt_req` stays 0; write 0xA3 → `fmt_req` = 1 next cycle. Grant two cycles later → `fmt_data` A0,A1,A2,A3 on consecutive cycles, `fmt_start` with A0, `fmt_end` with A3, exactly 4 `fifo_rd_en` pulses.
- **Back-to-back:** `pkt_len` = 3, preload 64 words 0..63, `fmt_grant` tied 1 → two 32-word packets 0..31 and 32..63, ≥1 idle cycle between `fmt_end` and the second `fmt_req`, `fifo_rd_en` never high while `fifo_rd_empty` = 1.
- **Length lock:** `pkt_len` = 1 with 8 words buffered; switch `pkt_len` to 3 during SEND → packet still 8 words; the next packet waits for 32 buffered words.
- **Reset mid-packet:** pull `rst_n` low at the 3rd word of a 16-word packet → outputs 0 at once, no `fmt_end`; after release, FIFO and reader are empty and idle.
- **Wrap:** stream 100 words (values 0..99) in 4-word packets with random grant delays of 0–5 cycles → output order 0..99 exact across pointer wrap, 25 start/end pairs.
